// File: rtl/rate_pkg.sv
// Shared rate-select encodings and period helper for the digit counter.
// Used by rate_digit_counter and rate_divider.
package rate_pkg;

  localparam logic [1:0] SPD_FAST    = 2'b00;
  localparam logic [1:0] SPD_1HZ     = 2'b01;
  localparam logic [1:0] SPD_HALF    = 2'b10;
  localparam logic [1:0] SPD_QUARTER = 2'b11;

  function automatic int unsigned period_cycles(
    input logic [1:0]  spd,
    input int unsigned hz
  );
    int unsigned p;
    p = 1;
    unique case (spd)
      SPD_FAST:    p = 1;
      SPD_1HZ:     p = hz;
      SPD_HALF:    p = 2 * hz;
      SPD_QUARTER: p = 4 * hz;
      default:     p = 1;
    endcase
    return p;
  endfunction

endpackage

// File: rtl/rate_divider.sv
// Down-counting period divider; zero flags that a digit advance is due.
// period carries the reload value, i.e. PERIOD-1.
module rate_divider
  import rate_pkg::*;
#(
  parameter int W = 1
) (
  input  logic         clock,
  input  logic         resetn,
  input  logic         enable,
  input  logic         reload,
  input  logic [W-1:0] period,
  output logic         zero
);

  logic [W-1:0] cnt;

  always_ff @(posedge clock) begin
    if (!resetn) begin
      cnt <= '0;
    end else if (reload) begin
      cnt <= period;
    end else if (enable && cnt != '0) begin
      cnt <= cnt - W'(1);
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/rate_digit_counter.sv
// Hex digit counter advancing at a selectable rate, with tick/wrap pulses.
// Optional parallel load when DIGIT_LOAD_EN is defined.
module rate_digit_counter
  import rate_pkg::*;
#(
  parameter int CLK_HZ = 50000000
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic       enable,
  input  logic [1:0] speed,
  input  logic       load,
  input  logic [3:0] load_val,
  output logic [3:0] digit,
  output logic       tick,
  output logic       wrap
);

  localparam int W =
    ($clog2(4 * CLK_HZ) < 1) ? 1 : $clog2(4 * CLK_HZ);

  logic [1:0]   spd_q;
  logic [W-1:0] per_m1;
  logic         zero;
  logic         ld;
  logic [3:0]   ld_val;
  logic         chg;
  logic         adv;
  logic         reload;

`ifdef DIGIT_LOAD_EN
  assign ld     = load;
  assign ld_val = load_val;
`else
  logic unused_load;
  assign unused_load = ^{load, load_val};
  assign ld     = 1'b0;
  assign ld_val = 4'h0;
`endif

  assign per_m1 = W'(period_cycles(speed, CLK_HZ) - 1);

  // Load outranks a speed change, which outranks counting.
  assign chg    = (speed != spd_q) && !ld;
  assign adv    = enable && zero && !chg && !ld;
  assign reload = ld || chg || adv;

  rate_divider #(
    .W(W)
  ) u_div (
    .clock  (clock),
    .resetn (resetn),
    .enable (enable),
    .reload (reload),
    .period (per_m1),
    .zero   (zero)
  );

  always_ff @(posedge clock) begin
    if (!resetn) begin
      digit <= 4'h0;
      tick  <= 1'b0;
      wrap  <= 1'b0;
      spd_q <= speed;
    end else begin
      spd_q <= speed;
      unique case (1'b1)
        ld: begin
          digit <= ld_val;
          tick  <= 1'b0;
          wrap  <= 1'b0;
        end
        adv: begin
          digit <= digit + 4'd1;
          tick  <= 1'b1;
          wrap  <= (digit == 4'hF);
        end
        default: begin
          tick  <= 1'b0;
          wrap  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rate_digit_counter.sv
// Directed and randomized checks of rate_digit_counter against a
// cycle-count reference model; build with DIGIT_LOAD_EN for load tests.
module tb_rate_digit_counter;

  localparam int HZ = 4;

`ifdef DIGIT_LOAD_EN
  localparam bit LOAD_ON = 1'b1;
`else
  localparam bit LOAD_ON = 1'b0;
`endif

  logic       clock;
  logic       resetn;
  logic       enable;
  logic [1:0] speed;
  logic       load;
  logic [3:0] load_val;
  logic [3:0] digit;
  logic       tick;
  logic       wrap;

  int checks   = 0;
  int failures = 0;

  int m_digit;
  int m_left;
  int m_spd;
  bit m_tick;
  bit m_wrap;

  rate_digit_counter #(
    .CLK_HZ(HZ)
  ) dut (
    .clock    (clock),
    .resetn   (resetn),
    .enable   (enable),
    .speed    (speed),
    .load     (load),
    .load_val (load_val),
    .digit    (digit),
    .tick     (tick),
    .wrap     (wrap)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic int cycles_for(input int s);
    if (s == 0) return 1;
    return HZ << (s - 1);
  endfunction

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // m_left = edges still to wait before the next enabled edge advances.
  task automatic model_edge();
    m_tick = 0;
    m_wrap = 0;
    if (!resetn) begin
      m_digit = 0;
      m_left  = 0;
    end else if (LOAD_ON && load) begin
      m_digit = int'(load_val);
      m_left  = cycles_for(int'(speed)) - 1;
    end else if (int'(speed) != m_spd) begin
      m_left  = cycles_for(int'(speed)) - 1;
    end else if (enable) begin
      if (m_left == 0) begin
        m_wrap  = (m_digit == 15);
        m_digit = (m_digit + 1) % 16;
        m_tick  = 1;
        m_left  = cycles_for(int'(speed)) - 1;
      end else begin
        m_left  = m_left - 1;
      end
    end
    m_spd = int'(speed);
  endtask

  task automatic step(input bit rn, input bit en, input logic [1:0] sp,
                      input bit ld, input logic [3:0] lv);
    resetn   = rn;
    enable   = en;
    speed    = sp;
    load     = ld;
    load_val = lv;
    @(posedge clock);
    #1;
    model_edge();
    chk("model_digit", int'(digit), m_digit);
    chk("model_tick", int'(tick), int'(m_tick));
    chk("model_wrap", int'(wrap), int'(m_wrap));
  endtask

  initial begin
    int hit;
    m_digit = 0;
    m_left  = 0;
    m_spd   = 0;
    resetn = 1'b0; enable = 1'b1; speed = 2'b00;
    load = 1'b0; load_val = 4'h0;

    // reset with enable high
    step(0, 1, 2'b00, 0, 4'h0);
    step(0, 1, 2'b00, 0, 4'h0);
    chk("rst_digit", int'(digit), 0);
    chk("rst_tick", int'(tick), 0);
    chk("rst_wrap", int'(wrap), 0);

    // fast count, 16 edges
    for (int i = 1; i <= 16; i++) begin
      step(1, 1, 2'b00, 0, 4'h0);
      chk("fast_digit", int'(digit), i % 16);
      chk("fast_tick", int'(tick), 1);
      chk("fast_wrap", int'(wrap), (i == 16) ? 1 : 0);
    end

    // 1 Hz rate from reset
    step(0, 1, 2'b01, 0, 4'h0);
    for (int k = 1; k <= 9; k++) begin
      step(1, 1, 2'b01, 0, 4'h0);
      chk("hz_digit", int'(digit), (k >= 9) ? 3 : (k >= 5) ? 2 : 1);
      chk("hz_tick", int'(tick), (k == 1 || k == 5 || k == 9) ? 1 : 0);
    end

    // enable hold mid-period: tick moves from edge 13 to edge 16
    step(1, 1, 2'b01, 0, 4'h0);
    for (int k = 0; k < 3; k++) begin
      step(1, 0, 2'b01, 0, 4'h0);
      chk("hold_digit", int'(digit), 3);
      chk("hold_tick", int'(tick), 0);
    end
    hit = 0;
    for (int k = 14; k <= 24 && hit == 0; k++) begin
      step(1, 1, 2'b01, 0, 4'h0);
      if (tick) hit = k;
    end
    chk("hold_tick_edge", hit, 16);
    chk("hold_digit_after", int'(digit), 4);

    // load at a due fast tick
    step(0, 1, 2'b00, 0, 4'h0);
    step(1, 1, 2'b00, 0, 4'h0);
    chk("pre_load_digit", int'(digit), 1);
    step(1, 1, 2'b00, 1, 4'hE);
    if (LOAD_ON) begin
      chk("load_digit", int'(digit), 14);
      chk("load_tick", int'(tick), 0);
      step(1, 1, 2'b00, 0, 4'h0);
      chk("load_next_f", int'(digit), 15);
      step(1, 1, 2'b00, 0, 4'h0);
      chk("load_wrap_digit", int'(digit), 0);
      chk("load_wrap", int'(wrap), 1);
    end else begin
      chk("noload_digit", int'(digit), 2);
      chk("noload_tick", int'(tick), 1);
    end

    // speed 01 -> 11 mid-period: next tick 16 edges after the change
    step(0, 1, 2'b01, 0, 4'h0);
    step(1, 1, 2'b01, 0, 4'h0);
    step(1, 1, 2'b01, 0, 4'h0);
    step(1, 1, 2'b11, 0, 4'h0);
    chk("chg_tick", int'(tick), 0);
    hit = 0;
    for (int k = 1; k <= 24 && hit == 0; k++) begin
      step(1, 1, 2'b11, 0, 4'h0);
      if (tick) hit = k;
    end
    chk("chg_tick_gap", hit, 16);
    chk("chg_digit", int'(digit), 2);

    // reset mid-count, then first enabled edge advances
    step(1, 1, 2'b11, 0, 4'h0);
    step(1, 1, 2'b11, 0, 4'h0);
    step(0, 1, 2'b11, 0, 4'h0);
    chk("midrst_digit", int'(digit), 0);
    step(1, 1, 2'b11, 0, 4'h0);
    chk("post_rst_digit", int'(digit), 1);
    chk("post_rst_tick", int'(tick), 1);

    // randomized traffic against the model
    for (int n = 0; n < 600; n++) begin
      bit         rn, en, ld;
      logic [1:0] sp;
      rn = ($urandom_range(0, 39) != 0);
      en = ($urandom_range(0, 3) != 0);
      ld = ($urandom_range(0, 15) == 0);
      sp = ($urandom_range(0, 9) == 0) ? 2'($urandom_range(0, 3)) : speed;
      if ($urandom_range(0, 1) == 0 && sp != 2'b00 &&
          $urandom_range(0, 3) == 0) sp = 2'b00;
      step(rn, en, sp, ld, 4'($urandom_range(0, 15)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rate_digit_counter.md
RATE_DIGIT_COUNTER -- requirements
Module: rate_digit_counter

Interface
REQ-001 SHALL have parameter CLK_HZ, default 50000000: clock cycles per 1 Hz tick period.
REQ-002 SHALL have port clock  input  1  system clock; all state updates on rising edge.
REQ-003 SHALL have port resetn  input  1  reset; one clock, reset is synchronous and active-low.
REQ-004 SHALL have port enable  input  1  count enable.
REQ-005 SHALL have port speed  input  2  rate select.
REQ-006 SHALL have port load  input  1  parallel-load request.
REQ-007 SHALL have port load_val  input  4  value to load.
REQ-008 SHALL have port digit  output  4  current hex digit, driving the downstream 7-segment decoder.
REQ-009 SHALL have port tick  output  1  one-cycle pulse, high in the cycle a new digit value first appears.
REQ-010 SHALL have port wrap  output  1  one-cycle pulse, high in the cycle digit changes F->0 by counting.

Function
REQ-011 SHALL derive PERIOD from speed: 00 = 1, 01 = CLK_HZ, 10 = 2*CLK_HZ, 11 = 4*CLK_HZ cycles.
REQ-012 SHALL hold a down-counting divider of width $clog2(4*CLK_HZ), minimum 1 bit.
REQ-013 SHALL, on an edge with enable=1 and divider=0: set digit to digit+1 mod 16, tick to 1, and divider to PERIOD-1.
REQ-014 SHALL, on an edge with enable=1 and divider!=0: decrement the divider, hold digit, and set tick to 0.
REQ-015 SHALL, on an edge with enable=0: hold divider and digit, and set tick and wrap to 0.
REQ-016 SHALL set wrap to 1 only on a REQ-013 edge where the old digit is F; otherwise wrap is 0.
REQ-017 SHALL register speed internally; an edge where speed differs from the registered value SHALL reload divider to the new PERIOD-1 with no tick, taking priority over REQ-013 and REQ-014.
REQ-018 SHALL register all outputs; there is no combinational path from any input to any output.
REQ-019 SHALL, with speed=00 and enable=1, advance digit on every edge.

Reset
REQ-020 SHALL, on an edge with resetn=0, set digit=0, tick=0, wrap=0, divider=0 and registered speed=current speed; reset overrides all other inputs.
REQ-021 SHALL abandon any partial period when reset is asserted mid-count; after release, the first advance occurs on the first enabled edge, since divider=0.

Configuration
REQ-022 SHALL, with DIGIT_LOAD_EN defined, act on load=1 at an edge (after reset, before all else) by setting digit=load_val, divider=PERIOD-1, tick=0 and wrap=0.
REQ-023 SHALL, with DIGIT_LOAD_EN undefined, ignore load and load_val; both ports remain present.

Structure
REQ-024 SHALL place speed-encoding constants (SPD_FAST, SPD_1HZ, SPD_HALF, SPD_QUARTER) in package rate_pkg.
REQ-025 SHALL implement the divider as sub-module rate_divider (inputs clock, resetn, enable, reload, period; output zero), with digit logic in the top.

Verification (CLK_HZ=4)
REQ-026 SHALL test reset: resetn=0 for 2 edges with enable=1 -> digit=0, tick=0, wrap=0.
REQ-027 SHALL test fast count: speed=00, enable=1 for 16 edges -> digit 1,2,...,F,0; tick high every cycle; wrap high only on the 16th cycle.
REQ-028 SHALL test 1 Hz rate: speed=01, enable=1 from reset -> digit=1 after edge 1, 2 after edge 5, 3 after edge 9; tick high only in those cycles.
REQ-029 SHALL test enable hold: at speed=01, drop enable for 3 edges mid-period -> digit and divider frozen; the next tick arrives 3 edges later than it would have without the hold.
REQ-030 SHALL test load with DIGIT_LOAD_EN: load=1, load_val=E at the same edge as a due tick -> digit=E, tick=0; the next enabled fast edge gives F, then 0 with wrap=1. Without DIGIT_LOAD_EN the same stimulus SHALL give digit+1 with tick=1.
REQ-031 SHALL test speed change and reset mid-count: changing speed 01->11 mid-period gives the next tick 16 edges later; resetn=0 mid-count gives digit=0 on the next edge.
